can_bit_sync: RTL and testbench
===============================

// Module: can_bit_sync
// PURPOSE
//  Receive-side CAN bit synchroniser, the counterpart of the bit-timing generator. Runs the tq prescaler and
//  per-bit segment FSM (SYNC/TSEG1/TSEG2) from btr_config and watches can_rx for recessive->dominant edges.
//  Applies hard sync at SOF and SJW-bounded resync, then emits the sample point and sampled bit to the
//  RX bit-stream logic. It also emits the bit boundary to the TX serializer.
// PARAMETERS
//  SYNC_STAGES  2  flops in can_rx metastability synchroniser (>=2)
// PORTS
//  clk_ref        in   1   block clock; the only clock
//  rst_n          in   1   reset, synchronous, active-low
//  enable         in   1   0: hold FSM idle (as reset) and drive no pulses
//  btr_config     in   32  [7:0] brp, [11:8] sjw, [15:12] seg1, [19:16] seg2; [31:20] ignored
//  can_rx         in   1   raw bus line, asynchronous; 1 = recessive
//  hard_sync_en   in   1   bus idle/intermission; next edge triggers a hard sync
//  sample_pulse   out  1   1-cycle pulse at the sample point
//  rx_bit         out  1   bit value captured at the last sample point
//  tx_point       out  1   1-cycle pulse at each bit start (SYNC entry, or early end of TSEG2)
//  hard_sync_ack  out  1   1-cycle pulse when a hard sync has been applied
//  resync_pulse   out  1   1-cycle pulse when a resync (lengthen or shorten) has been applied
// BEHAVIOUR
//  Reset / enable=0: all pulse outputs 0, rx_bit=1, state SYNC, tq_cnt=seg_cnt=0, resync_done=0,
//   sync chain=1.
//  Derived lengths: tseg1=seg1+1 (1..16); tseg2=max(seg2+1,2); sjw_eff=min(sjw+1,tseg2).
//   Derived lengths are latched on SYNC entry only; mid-bit btr_config changes take effect next bit.
//  Prescaler: tq_cnt counts 0..brp and wraps; tq_tick=(tq_cnt==brp), giving brp+1 clk_ref per tq.
//   Hard sync and early end of TSEG2 clear tq_cnt.
//  rx_s = can_rx after SYNC_STAGES flops. On each tq_tick, rx_tq<=rx_s.
//   edge = tq_tick & rx_tq & ~rx_s (recessive->dominant, tq granularity).
//  FSM, advanced on tq_tick only; seg_cnt is 6 bits.
//   SYNC: 1 tq, then ->TSEG1, seg_cnt=0, seg1_len=tseg1, seg2_len=tseg2.
//   TSEG1: when seg_cnt==seg1_len-1 -> TSEG2. Sample point: rx_bit<=rx_s, sample_pulse, resync_done<=0.
//   TSEG2: when seg_cnt==seg2_len-1 -> SYNC and tx_point.
//  Edge handling on the edge tick, in priority order:
//   1 hard_sync_en=1: ->TSEG1 with seg_cnt=0 (edge tq counts as SYNC). Assert hard_sync_ack and
//     tx_point; resync_done<=1.
//   2 resync_done=0 and rx_bit=1 (previous bit recessive):
//     SYNC: no action (phase error 0).
//     TSEG1 at seg_cnt=c: seg1_len<=tseg1+min(c+1,sjw_eff); resync_pulse; resync_done<=1.
//     TSEG2 at seg_cnt=c, with r=seg2_len-c:
//       if r<=sjw_eff: end bit now, ->TSEG1 with seg_cnt=0 (edge tq is SYNC); tx_point.
//       else seg2_len<=tseg2-sjw_eff.
//       Either way resync_pulse and resync_done<=1.
//   3 otherwise the edge is ignored (at most one resync between sample points).
//  Latency: every output pulse is registered, high for exactly one clk_ref cycle, in the cycle after the
//   causing tq_tick. rx_bit changes in that same cycle together with sample_pulse.
//  Sampling at the sample point uses rx_s, not rx_tq.
//  An edge on the same tick as a segment end: the edge rule wins; the segment-end transition is dropped.
//  rst_n low mid-bit: full restart per reset values on the next clk_ref edge. No partial-bit output.
// STRUCTURE
//  Shared can package gets:
//   - typedef enum logic [1:0] {SEG_SYNC, SEG_TSEG1, SEG_TSEG2} can_seg_e
//   - btr field-offset localparams (BRP_LSB=0, SJW_LSB=8, SEG1_LSB=12, SEG2_LSB=16)
//  One sub-module: can_rx_sync (SYNC_STAGES-deep flop chain, reset to 1). Prescaler, FSM and edge logic
//  live inline in this module.
// TESTING
//  Base config for all cases: brp=1, seg1=5, seg2=2, sjw=0 -> tq=2 clk, tseg1=6, tseg2=3, bit=10 tq=20 clk.
//  1 can_rx=1 held, enable=1 -> tx_point every 20 clk; sample_pulse 14 clk after each tx_point; rx_bit=1.
//  2 hard_sync_en=1, can_rx 1->0 mid-TSEG2 -> hard_sync_ack and tx_point together; sample_pulse exactly
//    12 clk later; rx_bit=0.
//  3 sjw=1 (sjw_eff=2), edge at TSEG1 seg_cnt=2 -> resync_pulse; that bit lasts 12 tq (24 clk) tx_point
//    to tx_point.
//  4 sjw=1, edge at TSEG2 seg_cnt=1 (r=2<=2) -> tx_point on the edge tick; next sample_pulse 12 clk later.
//  5 rx_bit=0 (previous bit dominant), then edge in TSEG1 -> no resync_pulse; bit period stays 20 clk.
//    A second edge within the same bit is also ignored.
//  6 rst_n=0 for 1 clk mid-TSEG1 -> next cycle all pulses 0 and rx_bit=1; first tx_point 20 clk after release.

Source files
------------

// File: rtl/can_bit_sync_pkg.sv
// Shared CAN bit-timing types, btr_config field offsets and derived segment lengths.
package can_bit_sync_pkg;

  typedef enum logic [1:0] {
    SEG_SYNC,
    SEG_TSEG1,
    SEG_TSEG2
  } can_seg_e;

  localparam int unsigned BRP_LSB  = 0;
  localparam int unsigned SJW_LSB  = 8;
  localparam int unsigned SEG1_LSB = 12;
  localparam int unsigned SEG2_LSB = 16;

  // Segment lengths in tq; 6 bits covers a fully lengthened TSEG1 (16 + 16).
  localparam int unsigned LEN_W = 6;

  function automatic logic [LEN_W-1:0] calc_tseg1(input logic [3:0] seg1);
    return {2'b00, seg1} + 6'd1;
  endfunction

  function automatic logic [LEN_W-1:0] calc_tseg2(input logic [3:0] seg2);
    return (seg2 == 4'd0) ? 6'd2 : {2'b00, seg2} + 6'd1;
  endfunction

  function automatic logic [LEN_W-1:0] calc_sjw(input logic [3:0] sjw,
                                                input logic [LEN_W-1:0] tseg2);
    logic [LEN_W-1:0] s;
    s = {2'b00, sjw} + 6'd1;
    return (s < tseg2) ? s : tseg2;
  endfunction

endpackage

// File: rtl/can_bit_sync_if.sv
// Control, bus-line and bit-event signals of the receive bit synchroniser.
interface can_bit_sync_if;
  logic        enable;
  logic [31:0] btr_config;
  logic        can_rx;
  logic        hard_sync_en;
  logic        sample_pulse;
  logic        rx_bit;
  logic        tx_point;
  logic        hard_sync_ack;
  logic        resync_pulse;

  modport master (
    output enable, btr_config, can_rx, hard_sync_en,
    input  sample_pulse, rx_bit, tx_point, hard_sync_ack, resync_pulse
  );

  modport slave (
    input  enable, btr_config, can_rx, hard_sync_en,
    output sample_pulse, rx_bit, tx_point, hard_sync_ack, resync_pulse
  );
endinterface

// File: rtl/can_rx_sync.sv
// Metastability synchroniser for the asynchronous CAN rx line; idles recessive.
module can_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n || hold) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/can_bit_sync.sv
// CAN receive bit synchroniser: tq prescaler, SYNC/TSEG1/TSEG2 segment FSM, hard sync and
// SJW-bounded resync, producing the sample point, sampled bit and bit-start pulses.
module can_bit_sync
  import can_bit_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk_ref,
  input logic           rst_n,
  can_bit_sync_if.slave bus
);

  logic [7:0]       brp;
  logic [3:0]       sjw;
  logic [3:0]       seg1;
  logic [3:0]       seg2;
  logic [LEN_W-1:0] cfg_tseg1;
  logic [LEN_W-1:0] cfg_tseg2;
  logic [LEN_W-1:0] cfg_sjw;
  logic             unused_cfg;

  logic             clear;
  logic             rx_s;
  logic             rx_tq;
  logic             rx_edge;
  logic [7:0]       tq_cnt;
  logic             tq_tick;
  logic             tq_clr;

  can_seg_e         state, state_next;
  logic [LEN_W-1:0] seg_cnt, seg_cnt_next;
  logic [LEN_W-1:0] seg1_len, seg1_len_next;
  logic [LEN_W-1:0] seg2_len, seg2_len_next;
  logic [LEN_W-1:0] sjw_len, sjw_len_next;
  logic             resync_done, resync_done_next;
  logic             rx_bit_q, rx_bit_next;

  logic [LEN_W-1:0] seg_inc;
  logic [LEN_W-1:0] lengthen;
  logic [LEN_W-1:0] remain;

  logic sp_q, sp_next;
  logic tx_q, tx_next;
  logic hs_q, hs_next;
  logic rs_q, rs_next;

  assign brp  = bus.btr_config[BRP_LSB  +: 8];
  assign sjw  = bus.btr_config[SJW_LSB  +: 4];
  assign seg1 = bus.btr_config[SEG1_LSB +: 4];
  assign seg2 = bus.btr_config[SEG2_LSB +: 4];
  assign unused_cfg = ^bus.btr_config[31:20];

  assign cfg_tseg1 = calc_tseg1(seg1);
  assign cfg_tseg2 = calc_tseg2(seg2);
  assign cfg_sjw   = calc_sjw(sjw, cfg_tseg2);

  assign clear = !rst_n || !bus.enable;

  can_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk  (clk_ref),
    .rst_n(rst_n),
    .hold (!bus.enable),
    .din  (bus.can_rx),
    .dout (rx_s)
  );

  assign tq_tick = (tq_cnt == brp);
  assign rx_edge = tq_tick && rx_tq && !rx_s;

  // While resync_done is clear, seg1_len/seg2_len still hold this bit's unmodified lengths.
  assign seg_inc  = seg_cnt + 6'd1;
  assign lengthen = (seg_inc < sjw_len) ? seg_inc : sjw_len;
  assign remain   = seg2_len - seg_cnt;

  always_comb begin
    state_next       = state;
    seg_cnt_next     = seg_cnt;
    seg1_len_next    = seg1_len;
    seg2_len_next    = seg2_len;
    sjw_len_next     = sjw_len;
    resync_done_next = resync_done;
    rx_bit_next      = rx_bit_q;
    tq_clr           = 1'b0;
    sp_next          = 1'b0;
    tx_next          = 1'b0;
    hs_next          = 1'b0;
    rs_next          = 1'b0;

    if (tq_tick) begin
      if (rx_edge && bus.hard_sync_en) begin
        state_next       = SEG_TSEG1;
        seg_cnt_next     = '0;
        seg1_len_next    = cfg_tseg1;
        seg2_len_next    = cfg_tseg2;
        sjw_len_next     = cfg_sjw;
        resync_done_next = 1'b1;
        tq_clr           = 1'b1;
        hs_next          = 1'b1;
        tx_next          = 1'b1;
      end else if (rx_edge && !resync_done && rx_bit_q && (state != SEG_SYNC)) begin
        resync_done_next = 1'b1;
        rs_next          = 1'b1;
        if (state == SEG_TSEG1) begin
          seg1_len_next = seg1_len + lengthen;
          seg_cnt_next  = seg_inc;
        end else if (remain <= sjw_len) begin
          state_next    = SEG_TSEG1;
          seg_cnt_next  = '0;
          seg1_len_next = cfg_tseg1;
          seg2_len_next = cfg_tseg2;
          sjw_len_next  = cfg_sjw;
          tq_clr        = 1'b1;
          tx_next       = 1'b1;
        end else begin
          seg2_len_next = seg2_len - sjw_len;
          seg_cnt_next  = seg_inc;
        end
      end else begin
        // Segment ends compare with >= so a shortened TSEG2 can never be overrun.
        unique case (state)
          SEG_SYNC: begin
            state_next    = SEG_TSEG1;
            seg_cnt_next  = '0;
            seg1_len_next = cfg_tseg1;
            seg2_len_next = cfg_tseg2;
            sjw_len_next  = cfg_sjw;
          end
          SEG_TSEG1: begin
            if (seg_cnt >= seg1_len - 6'd1) begin
              state_next       = SEG_TSEG2;
              seg_cnt_next     = '0;
              rx_bit_next      = rx_s;
              resync_done_next = 1'b0;
              sp_next          = 1'b1;
            end else begin
              seg_cnt_next = seg_inc;
            end
          end
          SEG_TSEG2: begin
            if (seg_cnt >= seg2_len - 6'd1) begin
              state_next   = SEG_SYNC;
              seg_cnt_next = '0;
              tx_next      = 1'b1;
            end else begin
              seg_cnt_next = seg_inc;
            end
          end
          default: begin
            state_next   = SEG_SYNC;
            seg_cnt_next = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_ref) begin
    if (clear) begin
      tq_cnt      <= '0;
      state       <= SEG_SYNC;
      seg_cnt     <= '0;
      seg1_len    <= '0;
      seg2_len    <= '0;
      sjw_len     <= '0;
      rx_tq       <= 1'b1;
      resync_done <= 1'b0;
      rx_bit_q    <= 1'b1;
      sp_q        <= 1'b0;
      tx_q        <= 1'b0;
      hs_q        <= 1'b0;
      rs_q        <= 1'b0;
    end else begin
      tq_cnt      <= (tq_tick || tq_clr) ? '0 : tq_cnt + 8'd1;
      state       <= state_next;
      seg_cnt     <= seg_cnt_next;
      seg1_len    <= seg1_len_next;
      seg2_len    <= seg2_len_next;
      sjw_len     <= sjw_len_next;
      rx_tq       <= tq_tick ? rx_s : rx_tq;
      resync_done <= resync_done_next;
      rx_bit_q    <= rx_bit_next;
      sp_q        <= sp_next;
      tx_q        <= tx_next;
      hs_q        <= hs_next;
      rs_q        <= rs_next;
    end
  end

  assign bus.sample_pulse  = sp_q;
  assign bus.rx_bit        = rx_bit_q;
  assign bus.tx_point      = tx_q;
  assign bus.hard_sync_ack = hs_q;
  assign bus.resync_pulse  = rs_q;

endmodule

// File: tb/tb_can_bit_sync.sv
// Scoreboard bench for can_bit_sync: expected pulses (kind, cycle after release, rx_bit) are
// queued as stimulus is driven and popped as the DUT raises each pulse.
module tb_can_bit_sync;

  localparam int K_TX = 0;
  localparam int K_HS = 1;
  localparam int K_RS = 2;
  localparam int K_SP = 3;

  typedef struct {
    int kind;
    int cyc;
    int rxb;
  } exp_t;

  logic clk_ref = 1'b0;
  logic rst_n   = 1'b0;

  can_bit_sync_if dif ();

  can_bit_sync #(
    .SYNC_STAGES(2)
  ) dut (
    .clk_ref(clk_ref),
    .rst_n  (rst_n),
    .bus    (dif)
  );

  always #5 clk_ref = ~clk_ref;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    t0     = 0;
  bit    mon_en = 1'b0;
  string tname  = "init";
  string knames[4] = '{"tx_point", "hard_sync_ack", "resync_pulse", "sample_pulse"};

  always @(posedge clk_ref) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d", tname, tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int c, input int rxb = 1);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.rxb  = rxb;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int kind);
    exp_t e;
    int   rel;
    rel = cyc - t0;
    if (sb.size() == 0) begin
      check_eq({"unexpected_", knames[kind]}, rel, -1);
    end else begin
      e = sb.pop_front();
      check_eq({knames[kind], "_kind"}, kind, e.kind);
      check_eq({knames[kind], "_cycle"}, rel, e.cyc);
      if (kind == K_SP) check_eq("rx_bit", int'(dif.rx_bit), e.rxb);
    end
  endtask

  always @(negedge clk_ref) begin
    if (mon_en) begin
      if (dif.tx_point)      sb_pop(K_TX);
      if (dif.hard_sync_ack) sb_pop(K_HS);
      if (dif.resync_pulse)  sb_pop(K_RS);
      if (dif.sample_pulse)  sb_pop(K_SP);
    end
  end

  function automatic logic [31:0] btr(input int sjw);
    logic [3:0] s;
    s = 4'(sjw);
    return {12'h000, 4'd2, 4'd5, s, 8'd1};
  endfunction

  function automatic int outs();
    return int'({dif.sample_pulse, dif.tx_point, dif.hard_sync_ack, dif.resync_pulse, dif.rx_bit});
  endfunction

  task automatic wait_rel(input int k);
    while ((cyc - t0) < k) @(negedge clk_ref);
  endtask

  task automatic restart(input string name, input int sjw);
    rst_n            = 1'b0;
    dif.enable       = 1'b1;
    dif.hard_sync_en = 1'b0;
    dif.can_rx       = 1'b1;
    dif.btr_config   = btr(sjw);
    repeat (2) @(negedge clk_ref);
    check_eq("sb_left", sb.size(), 0);
    sb.delete();
    tname = name;
    check_eq("reset_outs", outs(), 1);
    rst_n = 1'b1;
    t0    = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.enable       = 1'b1;
    dif.hard_sync_en = 1'b0;
    dif.can_rx       = 1'b1;
    dif.btr_config   = btr(0);
    repeat (2) @(negedge clk_ref);
    mon_en = 1'b1;

    // Recessive idle line: free-running bits, then a disable/enable restart.
    restart("idle", 0);
    expect_ev(K_SP, 14); expect_ev(K_TX, 20);
    expect_ev(K_SP, 34); expect_ev(K_TX, 40);
    expect_ev(K_SP, 54); expect_ev(K_TX, 60);
    wait_rel(65);
    dif.enable = 1'b0;
    repeat (10) @(negedge clk_ref);
    check_eq("disabled_outs", outs(), 1);
    dif.enable = 1'b1;
    t0 = cyc;
    expect_ev(K_SP, 14); expect_ev(K_TX, 20);
    wait_rel(24);

    // Hard sync on a falling edge in TSEG2.
    restart("hard_sync", 0);
    expect_ev(K_SP, 14);
    wait_rel(15);
    dif.can_rx = 1'b0;
    dif.hard_sync_en = 1'b1;
    expect_ev(K_TX, 18); expect_ev(K_HS, 18);
    expect_ev(K_SP, 30, 0); expect_ev(K_TX, 36);
    expect_ev(K_SP, 50, 0); expect_ev(K_TX, 56);
    wait_rel(19);
    dif.hard_sync_en = 1'b0;
    wait_rel(60);

    // Resync in TSEG1 clamped to sjw_eff=2, second edge before sample point ignored.
    restart("resync_tseg1", 1);
    expect_ev(K_SP, 14); expect_ev(K_TX, 20);
    wait_rel(25);
    dif.can_rx = 1'b0;
    expect_ev(K_RS, 28); expect_ev(K_SP, 38, 0); expect_ev(K_TX, 44);
    expect_ev(K_SP, 58, 0); expect_ev(K_TX, 64);
    wait_rel(29);
    dif.can_rx = 1'b1;
    wait_rel(31);
    dif.can_rx = 1'b0;
    wait_rel(66);

    // Edge in TSEG2 with r=2<=sjw_eff: bit ends on the edge tick.
    restart("resync_tseg2_end", 1);
    expect_ev(K_SP, 14);
    wait_rel(15);
    dif.can_rx = 1'b0;
    expect_ev(K_TX, 18); expect_ev(K_RS, 18);
    expect_ev(K_SP, 30, 0); expect_ev(K_TX, 36);
    expect_ev(K_SP, 50, 0); expect_ev(K_TX, 56);
    wait_rel(60);

    // Edge at TSEG2 start with r=3>sjw_eff=1: TSEG2 shortened to 2 tq.
    restart("resync_tseg2_short", 0);
    expect_ev(K_SP, 14);
    wait_rel(13);
    dif.can_rx = 1'b0;
    expect_ev(K_RS, 16); expect_ev(K_TX, 18);
    expect_ev(K_SP, 32, 0); expect_ev(K_TX, 38);
    wait_rel(42);

    // After a dominant sample, TSEG1 edges are ignored and the bit stays 20 clk.
    restart("dominant_ignore", 0);
    wait_rel(5);
    dif.can_rx = 1'b0;
    expect_ev(K_RS, 8); expect_ev(K_SP, 16, 0); expect_ev(K_TX, 22);
    expect_ev(K_SP, 36, 0); expect_ev(K_TX, 42);
    expect_ev(K_SP, 56, 0); expect_ev(K_TX, 62);
    wait_rel(23);
    dif.can_rx = 1'b1;
    wait_rel(25);
    dif.can_rx = 1'b0;
    wait_rel(27);
    dif.can_rx = 1'b1;
    wait_rel(29);
    dif.can_rx = 1'b0;
    wait_rel(64);

    // One-cycle reset in the middle of TSEG1 with rx_bit=0.
    restart("reset_mid_bit", 0);
    wait_rel(5);
    dif.can_rx = 1'b0;
    expect_ev(K_RS, 8); expect_ev(K_SP, 16, 0); expect_ev(K_TX, 22);
    wait_rel(28);
    rst_n = 1'b0;
    @(negedge clk_ref);
    check_eq("reset_next_outs", outs(), 1);
    rst_n      = 1'b1;
    dif.can_rx = 1'b1;
    t0         = cyc;
    expect_ev(K_SP, 14); expect_ev(K_TX, 20);
    wait_rel(24);

    check_eq("sb_left_final", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
